// File: rtl/pu_riscv_memalign_split_if.sv
// CPU-side request/response and data-bus beat signals for the misaligned access handler.
interface pu_riscv_memalign_split_if #(
    parameter int XLEN = 64
) ();
    localparam int N = XLEN / 8;

    // CPU load/store unit side
    logic            req_i;
    logic            we_i;
    logic [XLEN-1:0] adr_i;
    logic [2:0]      size_i;
    logic [XLEN-1:0] d_i;
    logic            ack_o;
    logic            err_o;
    logic [XLEN-1:0] q_o;

    // Data bus interface unit side
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_adr_o;
    logic [N-1:0]    mem_be_o;
    logic [XLEN-1:0] mem_d_o;
    logic            mem_ack_i;
    logic            mem_err_i;
    logic [XLEN-1:0] mem_q_i;

    // Handler view
    modport slave (
        input  req_i, we_i, adr_i, size_i, d_i,
        output ack_o, err_o, q_o,
        output mem_req_o, mem_we_o, mem_adr_o, mem_be_o, mem_d_o,
        input  mem_ack_i, mem_err_i, mem_q_i
    );

    // CPU plus memory view (drives requests and bus responses)
    modport master (
        output req_i, we_i, adr_i, size_i, d_i,
        input  ack_o, err_o, q_o,
        input  mem_req_o, mem_we_o, mem_adr_o, mem_be_o, mem_d_o,
        output mem_ack_i, mem_err_i, mem_q_i
    );
endinterface

// File: rtl/pu_riscv_memalign_split.sv
// Misaligned data access handler: splits any-alignment loads/stores into one or two
// naturally aligned bus beats and reassembles load data right-justified.
module pu_riscv_memalign_split #(
    parameter int XLEN = 64
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    pu_riscv_memalign_split_if.slave     bus
);
    localparam int N  = XLEN / 8;
    localparam int OW = $clog2(N);

    localparam logic [2:0] SizeDword = 3'b011;
    localparam logic [OW+3:0] XlenW = (OW + 4)'(XLEN);

    typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StResp} state_e;

    state_e state_q, state_d;

    logic            we_q, we_d;
    logic [XLEN-1:0] adr_q, adr_d;      // beat-1 aligned address
    logic [OW-1:0]   off_q, off_d;
    logic [3:0]      bytes_q, bytes_d;
    logic [4:0]      end_q, end_d;      // off + bytes
    logic            split_q, split_d;
    logic [XLEN-1:0] dat_q, dat_d;      // store data
    logic [XLEN-1:0] lo_q, lo_d;        // beat-1 load part, already shifted down

    logic            ack_q, ack_d, err_q, err_d;
    logic [XLEN-1:0] q_q, q_d;
    logic            mreq_q, mreq_d, mwe_q, mwe_d;
    logic [XLEN-1:0] madr_q, madr_d, md_q, md_d;
    logic [N-1:0]    mbe_q, mbe_d;

    logic [OW-1:0]   off_in;
    logic [3:0]      bytes_in;
    logic [4:0]      end_in;
    logic            illegal_in;
    logic [OW+2:0]   sh_lo_in, sh_lo_q;
    logic [OW+3:0]   sh_hi_q;

    // Byte enables for lanes lo <= i < hi
    function automatic logic [N-1:0] be_window(input int lo, input int hi);
        logic [N-1:0] be;
        for (int i = 0; i < N; i++) be[i] = (i >= lo) && (i < hi);
        return be;
    endfunction

    // Keeps the low nbytes bytes of a word
    function automatic logic [XLEN-1:0] byte_mask(input int nbytes);
        logic [XLEN-1:0] m;
        for (int i = 0; i < N; i++) m[8*i +: 8] = (i < nbytes) ? 8'hFF : 8'h00;
        return m;
    endfunction

    assign off_in     = bus.adr_i[OW-1:0];
    assign bytes_in   = 4'd1 << bus.size_i[1:0];
    assign end_in     = 5'(off_in) + 5'(bytes_in);
    assign illegal_in = (bus.size_i > SizeDword) || ((bus.size_i == SizeDword) && (XLEN == 32));
    assign sh_lo_in   = {off_in, 3'b000};
    assign sh_lo_q    = {off_q, 3'b000};
    assign sh_hi_q    = XlenW - {1'b0, off_q, 3'b000};

    // Next-state, request latching and registered output values
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        off_d   = off_q;
        bytes_d = bytes_q;
        end_d   = end_q;
        split_d = split_q;
        dat_d   = dat_q;
        lo_d    = lo_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        q_d     = '0;
        mreq_d  = mreq_q;
        mwe_d   = mwe_q;
        madr_d  = madr_q;
        mbe_d   = mbe_q;
        md_d    = md_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    adr_d   = {bus.adr_i[XLEN-1:OW], {OW{1'b0}}};
                    off_d   = off_in;
                    bytes_d = bytes_in;
                    end_d   = end_in;
                    split_d = end_in > 5'(N);
                    dat_d   = bus.d_i;
                    if (illegal_in) begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StBeat1;
                        mreq_d  = 1'b1;
                        mwe_d   = bus.we_i;
                        madr_d  = {bus.adr_i[XLEN-1:OW], {OW{1'b0}}};
                        mbe_d   = be_window(int'(off_in), int'(end_in));
                        md_d    = bus.d_i << sh_lo_in;
                    end
                end
            end
            StBeat1: begin
                if (bus.mem_ack_i) begin
                    if (!bus.mem_err_i && split_q) begin
                        state_d = StBeat2;
                        lo_d    = bus.mem_q_i >> sh_lo_q;
                        madr_d  = adr_q + XLEN'(N);
                        mbe_d   = be_window(0, int'(end_q) - N);
                        md_d    = dat_q >> sh_hi_q;
                    end else begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                        err_d   = bus.mem_err_i;
                        if (!bus.mem_err_i && !we_q) begin
                            q_d = (bus.mem_q_i >> sh_lo_q) & byte_mask(int'(bytes_q));
                        end
                        mreq_d  = 1'b0;
                        mwe_d   = 1'b0;
                        madr_d  = '0;
                        mbe_d   = '0;
                        md_d    = '0;
                    end
                end
            end
            StBeat2: begin
                if (bus.mem_ack_i) begin
                    state_d = StResp;
                    ack_d   = 1'b1;
                    err_d   = bus.mem_err_i;
                    if (!we_q) begin
                        q_d = (lo_q | (bus.mem_q_i << sh_hi_q)) & byte_mask(int'(bytes_q));
                    end
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    madr_d  = '0;
                    mbe_d   = '0;
                    md_d    = '0;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Latched request and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            off_q   <= '0;
            bytes_q <= '0;
            end_q   <= '0;
            split_q <= 1'b0;
            dat_q   <= '0;
            lo_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            madr_q  <= '0;
            mbe_q   <= '0;
            md_q    <= '0;
        end else begin
            we_q    <= we_d;
            adr_q   <= adr_d;
            off_q   <= off_d;
            bytes_q <= bytes_d;
            end_q   <= end_d;
            split_q <= split_d;
            dat_q   <= dat_d;
            lo_q    <= lo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            q_q     <= q_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            madr_q  <= madr_d;
            mbe_q   <= mbe_d;
            md_q    <= md_d;
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.err_o     = err_q;
    assign bus.q_o       = q_q;
    assign bus.mem_req_o = mreq_q;
    assign bus.mem_we_o  = mwe_q;
    assign bus.mem_adr_o = madr_q;
    assign bus.mem_be_o  = mbe_q;
    assign bus.mem_d_o   = md_q;

endmodule

// File: tb/tb_pu_riscv_memalign_split.sv
// Directed vector bench for pu_riscv_memalign_split (XLEN=64) with a wait-state memory responder.
module tb_pu_riscv_memalign_split;

    logic clk;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;

    pu_riscv_memalign_split_if #(.XLEN(64)) bus ();

    pu_riscv_memalign_split #(.XLEN(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [63:0] adr;
        logic [2:0]  size;
        logic [63:0] d;
        logic [63:0] q1;
        logic        e1;
        logic [63:0] q2;
        logic        e2;
        int          waits;
        int          beats;
        logic [63:0] adr1;
        logic [7:0]  be1;
        logic [63:0] d1;
        logic [63:0] adr2;
        logic [7:0]  be2;
        logic [63:0] d2;
        logic        err;
        logic [63:0] q;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".ack"},     64'(bus.ack_o),     64'h0);
        check({tag, ".err"},     64'(bus.err_o),     64'h0);
        check({tag, ".q"},       bus.q_o,            64'h0);
        check({tag, ".mem_req"}, 64'(bus.mem_req_o), 64'h0);
        check({tag, ".mem_we"},  64'(bus.mem_we_o),  64'h0);
        check({tag, ".mem_adr"}, bus.mem_adr_o,      64'h0);
        check({tag, ".mem_be"},  64'(bus.mem_be_o),  64'h0);
        check({tag, ".mem_d"},   bus.mem_d_o,        64'h0);
    endtask

    // Called at a negedge; extra = idle cycles before the DUT can sample req_i
    task automatic run_vec(input vec_t v, input int extra, input string tag);
        int beat = 0;
        int wcnt = 0;
        int cyc  = 0;
        int exp_lat;
        bit done = 0;
        exp_lat = (v.beats == 0) ? 1 + extra : 1 + extra + v.beats * (v.waits + 1);
        bus.req_i  = 1'b1;
        bus.we_i   = v.we;
        bus.adr_i  = v.adr;
        bus.size_i = v.size;
        bus.d_i    = v.d;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            cyc++;
            bus.mem_ack_i = 1'b0;
            bus.mem_err_i = 1'b0;
            bus.mem_q_i   = '0;
            if (bus.ack_o) begin
                check({tag, ".err"},     64'(bus.err_o),     64'(v.err));
                check({tag, ".q"},       bus.q_o,            v.q);
                check({tag, ".beats"},   64'(beat),          64'(v.beats));
                check({tag, ".latency"}, 64'(cyc),           64'(exp_lat));
                check({tag, ".req_low"}, 64'(bus.mem_req_o), 64'h0);
                bus.req_i = 1'b0;
                done = 1;
            end else if (bus.mem_req_o) begin
                if (wcnt == 0) begin
                    if (beat == 0) begin
                        check({tag, ".we"},   64'(bus.mem_we_o), 64'(v.we));
                        check({tag, ".adr1"}, bus.mem_adr_o,     v.adr1);
                        check({tag, ".be1"},  64'(bus.mem_be_o), 64'(v.be1));
                        check({tag, ".d1"},   bus.mem_d_o,       v.d1);
                    end else if (beat == 1) begin
                        check({tag, ".adr2"}, bus.mem_adr_o,     v.adr2);
                        check({tag, ".be2"},  64'(bus.mem_be_o), 64'(v.be2));
                        check({tag, ".d2"},   bus.mem_d_o,       v.d2);
                    end
                end
                if (wcnt == v.waits) begin
                    bus.mem_ack_i = 1'b1;
                    bus.mem_q_i   = (beat == 0) ? v.q1 : v.q2;
                    bus.mem_err_i = (beat == 0) ? v.e1 : v.e2;
                    beat++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        if (!done) begin
            check({tag, ".timeout"}, 64'h0, 64'h1);
            bus.req_i = 1'b0;
        end
    endtask

    initial begin
        int n;
        bit saw_b2;

        //              we    adr                     size    d                      q1                     e1    q2                     e2    w  b  adr1                   be1    d1                     adr2     be2    d2         err   q
        vecs[0]  = '{1'b0, 64'h1004,               3'b010, 64'h0,                 64'h89ABCDEF01234567,  1'b0, 64'h0,                 1'b0, 0, 1, 64'h1000,              8'hF0, 64'h0,                 64'h0,    8'h00, 64'h0,     1'b0, 64'h89ABCDEF};
        vecs[1]  = '{1'b0, 64'h1006,               3'b011, 64'h0,                 64'h1122334455667788,  1'b0, 64'h99AABBCCDDEEFF00,  1'b0, 1, 2, 64'h1000,              8'hC0, 64'h0,                 64'h1008, 8'h3F, 64'h0,     1'b0, 64'hBBCCDDEEFF001122};
        vecs[2]  = '{1'b1, 64'h2007,               3'b001, 64'hBEEF,              64'hDEADDEADDEADDEAD,  1'b0, 64'hDEADDEADDEADDEAD,  1'b0, 1, 2, 64'h2000,              8'h80, 64'hEF00000000000000,  64'h2008, 8'h01, 64'hBE,    1'b0, 64'h0};
        vecs[3]  = '{1'b1, 64'h2007,               3'b001, 64'hBEEF,              64'h0,                 1'b1, 64'h0,                 1'b0, 0, 1, 64'h2000,              8'h80, 64'hEF00000000000000,  64'h0,    8'h00, 64'h0,     1'b1, 64'h0};
        vecs[4]  = '{1'b0, 64'h1006,               3'b011, 64'h0,                 64'h1122334455667788,  1'b0, 64'h99AABBCCDDEEFF00,  1'b1, 0, 2, 64'h1000,              8'hC0, 64'h0,                 64'h1008, 8'h3F, 64'h0,     1'b1, 64'hBBCCDDEEFF001122};
        vecs[5]  = '{1'b0, 64'h1234,               3'b111, 64'h0,                 64'h0,                 1'b0, 64'h0,                 1'b0, 0, 0, 64'h0,                 8'h00, 64'h0,                 64'h0,    8'h00, 64'h0,     1'b1, 64'h0};
        vecs[6]  = '{1'b0, 64'hFFFFFFFFFFFFFFFE,   3'b010, 64'h0,                 64'h1122334455667788,  1'b0, 64'h99AABBCCDDEEFF00,  1'b0, 2, 2, 64'hFFFFFFFFFFFFFFF8,  8'hC0, 64'h0,                 64'h0,    8'h03, 64'h0,     1'b0, 64'hFF001122};
        vecs[7]  = '{1'b0, 64'h3003,               3'b000, 64'h0,                 64'h1122334455667788,  1'b0, 64'h0,                 1'b0, 0, 1, 64'h3000,              8'h08, 64'h0,                 64'h0,    8'h00, 64'h0,     1'b0, 64'h55};
        vecs[8]  = '{1'b1, 64'h4000,               3'b011, 64'h0123456789ABCDEF,  64'hFFFFFFFFFFFFFFFF,  1'b0, 64'h0,                 1'b0, 0, 1, 64'h4000,              8'hFF, 64'h0123456789ABCDEF,  64'h0,    8'h00, 64'h0,     1'b0, 64'h0};
        vecs[9]  = '{1'b0, 64'h5006,               3'b001, 64'h0,                 64'h1122334455667788,  1'b0, 64'h0,                 1'b0, 0, 1, 64'h5000,              8'hC0, 64'h0,                 64'h0,    8'h00, 64'h0,     1'b0, 64'h1122};
        vecs[10] = '{1'b1, 64'h6003,               3'b011, 64'h0123456789ABCDEF,  64'h0,                 1'b0, 64'h0,                 1'b0, 0, 2, 64'h6000,              8'hF8, 64'h6789ABCDEF000000,  64'h6008, 8'h07, 64'h012345, 1'b0, 64'h0};

        rst_ni        = 1'b0;
        bus.req_i     = 1'b0;
        bus.we_i      = 1'b0;
        bus.adr_i     = '0;
        bus.size_i    = '0;
        bus.d_i       = '0;
        bus.mem_ack_i = 1'b0;
        bus.mem_err_i = 1'b0;
        bus.mem_q_i   = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            run_vec(vecs[i], 0, $sformatf("v%0d", i));
        end

        // Back-to-back: req_i stays high across the RESP cycle into a new request
        @(negedge clk);
        run_vec(vecs[0], 0, "b2b_a");
        run_vec(vecs[2], 1, "b2b_b");

        // Reset asserted mid-access while beat 2 is waiting
        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.adr_i  = 64'h1006;
        bus.size_i = 3'b011;
        bus.d_i    = '0;
        saw_b2 = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            bus.mem_q_i   = '0;
            if (bus.mem_req_o && bus.mem_adr_o == 64'h1000) begin
                bus.mem_ack_i = 1'b1;
                bus.mem_q_i   = 64'h1122334455667788;
            end else if (bus.mem_req_o && bus.mem_adr_o == 64'h1008) begin
                saw_b2 = 1;
                n++;
                if (n == 3) break;
            end
        end
        check("rst.reached_beat2", 64'(saw_b2), 64'h1);
        #2 rst_ni = 1'b0;
        #1 check_quiet("rst_async");
        bus.req_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 0, "post_rst");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pu_riscv_memalign_split.md
# pu_riscv_memalign_split

Data-side misaligned access handler between the CPU load/store unit and the data bus interface unit. It accepts byte-addressed loads and stores of any alignment and issues one or two naturally aligned, full-width bus beats with byte enables. For loads it reassembles the read data, right-justified. It is the servicing counterpart of the misalignment flag: accesses the flag would trap on are executed transparently instead.

## Interface
Parameters:
- XLEN, 64, data width and bus beat width in bits (32 or 64); beat size N = XLEN/8 bytes
- Size codes are BYTE=3'b000, HWORD=3'b001, WORD=3'b010, DWORD=3'b011, all from peripheral_biu_verilog_pkg

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  CPU access request; held with all request fields stable until ack_o
- we_i  in  1  1 = store, 0 = load
- adr_i  in  XLEN  byte address
- size_i  in  3  access size code
- d_i  in  XLEN  store data, right-justified
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  error qualifier; valid only while ack_o is high
- q_o  out  XLEN  load data, right-justified and zero-extended; valid only while ack_o is high
- mem_req_o  out  1  bus beat request
- mem_we_o  out  1  beat write enable
- mem_adr_o  out  XLEN  beat address; low log2(N) bits are always 0
- mem_be_o  out  N  beat byte enables
- mem_d_o  out  XLEN  beat write data, byte-lane aligned
- mem_ack_i  in  1  beat complete
- mem_err_i  in  1  beat error; qualified by mem_ack_i
- mem_q_i  in  XLEN  beat read data; qualified by mem_ack_i

## Operation
- Terms: bytes B = 1 << size_i. Offset off = adr_i mod N. Split is required when off + B > N.
- Illegal size: size_i > DWORD, or DWORD when XLEN=32. An illegal request gets ack_o with err_o=1, performs no bus beat, and drives q_o=0.
- Request latching: in IDLE, req_i=1 latches the request and computes split, off and B. req_i is ignored in every other state.
- State machine, all outputs registered:
  - IDLE: on a legal req_i go to BEAT1. On an illegal req_i go to RESP with err set.
  - BEAT1: drive mem_adr_o = adr_i with low bits cleared, mem_be_o = ((1<<B)-1) << off truncated to N bits, mem_d_o = d_i << 8·off.
    - On mem_ack_i with mem_err_i=1: go to RESP with err set. Beat 2 is never issued.
    - On mem_ack_i with no error and split=1: capture mem_q_i >> 8·off into the low part and go to BEAT2.
    - On mem_ack_i with no error and split=0: go to RESP with q = (mem_q_i >> 8·off) masked to B bytes.
  - BEAT2: drive mem_adr_o = beat-1 address + N (wraps modulo 2^XLEN), mem_be_o = (1 << (off+B-N)) - 1, mem_d_o = d_i >> 8·(N-off).
    - On mem_ack_i: q = low part | (mem_q_i << 8·(N-off)), masked to B bytes. err = mem_err_i. Go to RESP.
  - RESP: ack_o=1 for one cycle with err_o and q_o valid, then go to IDLE.
- mem_req_o is 1 in BEAT1 and BEAT2 and 0 otherwise. mem_we_o = latched we_i whenever mem_req_o=1.
- Stores: a split store writes the low bytes in beat 1 and the high bytes in beat 2. If beat 1 errors, no bytes are written in beat 2.
- Loads drive q_o; stores drive q_o=0.

## Timing
- Reset values: ack_o=0, err_o=0, q_o=0, mem_req_o=0, mem_we_o=0, mem_adr_o=0, mem_be_o=0, mem_d_o=0; state=IDLE. Asserting rst_ni low mid-access forces these values immediately and abandons the access.
- Bus handshake: mem_req_o and the beat fields are held stable until the cycle in which mem_ack_i=1. An ack in the same cycle that mem_req_o first rises is legal. mem_ack_i is ignored while mem_req_o=0.
- Beat transition: BEAT1 to BEAT2 keeps mem_req_o high continuously; the beat fields change on the clock edge after the beat-1 ack.
- Latency with zero-wait memory (req_i sampled at T0):
  - single beat: mem_req_o at T1, ack_o at T2
  - split: beats at T1 and T2, ack_o at T3
  - illegal size: ack_o at T1
  - each memory wait cycle adds one cycle
- Back-to-back: the CPU may hold req_i high after ack_o for a new request; it is sampled in the IDLE cycle following RESP.
- Ordering: throughput is one request at a time; no pipelining.

## Test plan
- Aligned load (XLEN=64): WORD at 0x1004, mem_q_i=0x89ABCDEF_01234567 -> one beat, adr 0x1000, be 0xF0; q_o=0x89ABCDEF at T2.
- Split load: DWORD at 0x1006, beat 1 returns 0x1122334455667788, beat 2 returns 0x99AABBCCDDEEFF00 -> be 0xC0 then 0x3F at adr 0x1000/0x1008; q_o=0xBBCCDDEEFF001122 at T3.
- Split store: HWORD at 0x2007, d_i=0xBEEF -> beat 1 be 0x80 with mem_d_o[63:56]=0xEF; beat 2 adr 0x2008, be 0x01, mem_d_o[7:0]=0xBE.
- Error on beat 1 of a split store -> no beat 2, ack_o with err_o=1. Error on beat 2 only -> ack_o with err_o=1 after both beats.
- Illegal size_i=3'b111 -> no mem_req_o, ack_o and err_o at T1. Address 0xFFFF_FFFF_FFFF_FFFC WORD+2 split -> beat 2 adr wraps to 0.
- rst_ni low during BEAT2 with 3 wait cycles -> all outputs 0 asynchronously; next req_i starts cleanly from IDLE.
